// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_hs transaction sequencer: drives ap_start for a programmed number of
// transactions, checks the ready/done handshake, and records per-transaction latency.
module ap_ctrl_sequencer #(
  parameter int TXN_W       = 16,
  parameter int LAT_W       = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [TXN_W-1:0] cfg_num_txn,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [TXN_W-1:0] txn_done,
  output logic [LAT_W-1:0] lat_last,
  output logic [LAT_W-1:0] lat_max,
  output logic             proto_err,
  output logic             timeout_err
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC);
  localparam logic [LAT_W-1:0] LAT_SAT  = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    FINISH,
    ERROR
  } StateT;

  StateT            state, stateNext;
  logic [TXN_W-1:0] numTxn, numTxnNext;
  logic [TXN_W-1:0] txnNext;
  logic [LAT_W-1:0] latCnt, latCntNext;
  logic [LAT_W-1:0] lastNext, maxNext;
  logic [WD_W-1:0]  wdCnt, wdCntNext;
  logic             protoNext, timeoutNext;
  logic             complete;
  logic             lastTxn;
  logic [LAT_W-1:0] latInc;
  logic [WD_W-1:0]  wdInc;
  logic             wdExpire;

  always_comb begin
    stateNext   = state;
    numTxnNext  = numTxn;
    txnNext     = txn_done;
    latCntNext  = latCnt;
    lastNext    = lat_last;
    maxNext     = lat_max;
    wdCntNext   = wdCnt;
    protoNext   = proto_err;
    timeoutNext = timeout_err;
    complete    = 1'b0;
    lastTxn     = ((txn_done + TXN_W'(1)) == numTxn);
    latInc      = (latCnt == LAT_SAT) ? latCnt : latCnt + LAT_W'(1);
    wdInc       = wdCnt + WD_W'(1);
    wdExpire    = (TIMEOUT_CYC != 0) && (wdInc == WD_LIMIT);

    case (state)
      IDLE, FINISH: begin
        if (go) begin
          protoNext   = 1'b0;
          timeoutNext = 1'b0;
          if (cfg_num_txn != '0) begin
            numTxnNext = cfg_num_txn;
            txnNext    = '0;
            lastNext   = '0;
            maxNext    = '0;
            wdCntNext  = '0;
            latCntNext = LAT_W'(1);
            stateNext  = START;
          end else begin
            stateNext = FINISH;
          end
        end
      end

      START: begin
        if (ap_done && !ap_ready) begin
          protoNext = 1'b1;
          stateNext = ERROR;
        end else if (ap_ready && ap_done) begin
          complete   = 1'b1;
          wdCntNext  = '0;
          latCntNext = LAT_W'(1);
          stateNext  = lastTxn ? FINISH : START;
        end else if (ap_ready) begin
          wdCntNext  = '0;
          latCntNext = latInc;
          stateNext  = WAIT_DONE;
        end else begin
          latCntNext = latInc;
          if (wdExpire) begin
            timeoutNext = 1'b1;
            stateNext   = ERROR;
          end else if (TIMEOUT_CYC != 0) begin
            wdCntNext = wdInc;
          end
        end
      end

      WAIT_DONE: begin
        // A second ready before done means the hart accepted an unissued start.
        if (ap_ready) begin
          protoNext = 1'b1;
          stateNext = ERROR;
        end else if (ap_done) begin
          complete   = 1'b1;
          wdCntNext  = '0;
          latCntNext = LAT_W'(1);
          stateNext  = lastTxn ? FINISH : START;
        end else begin
          latCntNext = latInc;
          if (wdExpire) begin
            timeoutNext = 1'b1;
            stateNext   = ERROR;
          end else if (TIMEOUT_CYC != 0) begin
            wdCntNext = wdInc;
          end
        end
      end

      ERROR: begin
        stateNext = ERROR;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (complete) begin
      txnNext  = txn_done + TXN_W'(1);
      lastNext = latCnt;
      maxNext  = (latCnt > lat_max) ? latCnt : lat_max;
    end
  end

  // Handshake outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      numTxn      <= '0;
      latCnt      <= '0;
      wdCnt       <= '0;
      txn_done    <= '0;
      lat_last    <= '0;
      lat_max     <= '0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      state       <= stateNext;
      numTxn      <= numTxnNext;
      latCnt      <= latCntNext;
      wdCnt       <= wdCntNext;
      txn_done    <= txnNext;
      lat_last    <= lastNext;
      lat_max     <= maxNext;
      proto_err   <= protoNext;
      timeout_err <= timeoutNext;
      ap_start    <= (stateNext == START);
      busy        <= (stateNext == START) || (stateNext == WAIT_DONE);
      finish      <= (stateNext == FINISH) || (stateNext == ERROR);
    end
  end

endmodule

// File: doc/ap_ctrl_sequencer.md
# ap_ctrl_sequencer

Synthesizable ap_ctrl_hs transaction sequencer that sits directly upstream of the hart top-level in the co-simulation harness. It drives the hart's ap_start for a programmed number of back-to-back transactions and checks the ap_ready/ap_done handshake. It records per-transaction latency and raises the `finish` signal consumed by the dataflow status monitors. It replaces the ad-hoc testbench stimulus loop with a cycle-deterministic block.

## Interface
- TXN_W, 16, width of transaction counters
- LAT_W, 32, width of latency counters (saturating)
- TIMEOUT_CYC, 100000, watchdog limit in cycles without ap_ready/ap_done; 0 disables the watchdog
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- go  in  1  start pulse; sampled only in IDLE, FINISH
- cfg_num_txn  in  TXN_W  transactions to run; latched on accepted go
- ap_start  out  1  to hart
- ap_ready  in  1  from hart
- ap_done  in  1  from hart (one-cycle pulse)
- busy  out  1  high in START, WAIT_DONE
- finish  out  1  high in FINISH or ERROR; drives monitor `finish`
- txn_done  out  TXN_W  completed transactions in current run
- lat_last  out  LAT_W  latency of most recent transaction
- lat_max  out  LAT_W  maximum latency in current run
- proto_err  out  1  sticky handshake violation
- timeout_err  out  1  sticky watchdog expiry

## Operation
- States: IDLE, START, WAIT_DONE, FINISH, ERROR. At most one outstanding transaction.
- IDLE / FINISH, go=1:
  - cfg_num_txn≠0: latch N=cfg_num_txn; clear txn_done, lat_last, lat_max, watchdog; go to START.
  - cfg_num_txn=0: go to FINISH.
- START: ap_start=1.
  - ap_ready&ap_done: complete the transaction. If txn_done+1==N, go to FINISH; else stay in START (ap_start remains high, back-to-back).
  - ap_ready&!ap_done: go to WAIT_DONE.
  - ap_done&!ap_ready: set proto_err; go to ERROR.
- WAIT_DONE: ap_start=0.
  - ap_done: complete the transaction; go to FINISH if txn_done+1==N, else START.
  - ap_ready: set proto_err; go to ERROR.
- Completing a transaction:
  - txn_done += 1.
  - lat_last ← latency of that transaction.
  - lat_max ← max(lat_max, that latency).
- Latency definition: cycles from the first ap_start=1 cycle of the transaction through the ap_done cycle, inclusive. ready&done in the first START cycle gives 1. The latency counter saturates at 2^LAT_W−1 and restarts at 1 on the first cycle of each new transaction.
- Watchdog:
  - Counts cycles in START/WAIT_DONE; cleared on any cycle with ap_ready|ap_done.
  - If TIMEOUT_CYC≠0 and the count reaches TIMEOUT_CYC: set timeout_err; go to ERROR.
  - If expiry and a handshake violation occur in the same cycle, set proto_err only.
- ERROR: ap_start=0, finish=1. go is ignored; only reset exits ERROR.
- go while busy is ignored. A go accepted in FINISH clears proto_err/timeout_err (unreachable there, since they are set only in ERROR) and starts a new run.

## Timing
- All outputs are registered.
- Reset values: ap_start=0, busy=0, finish=0, txn_done=0, lat_last=0, lat_max=0, proto_err=0, timeout_err=0; state=IDLE.
- Reset asserted mid-run: the next edge forces all reset values, including ap_start=0, with no completion recorded.
- go accepted at edge k: ap_start=1 and busy=1 at k+1.
- Completing handshake at edge k:
  - txn_done, lat_last, lat_max are updated at k+1.
  - If it was the last transaction: finish=1 and ap_start=0 at k+1.
  - Back-to-back case: ap_start is never deasserted between transactions.
- ap_ready/ap_done are sampled at the rising edge.
- finish stays high until the next accepted go (FINISH) or reset (ERROR).

## Test plan
- N=3, hart asserts ready&done together 4 cycles after each start → ap_start high continuously 12 cycles; txn_done=3; lat_last=lat_max=4; finish=1 the cycle after the 3rd done.
- N=2, ready at cycle 2, done at cycle 6 (then ready 1, done 10) → ap_start low during WAIT_DONE; lat_last=10, lat_max=10; proto_err=0.
- ap_done pulse while in START without ap_ready → proto_err=1, finish=1, ap_start=0 next cycle; subsequent go has no effect.
- TIMEOUT_CYC=20, hart never responds → timeout_err=1, finish=1 exactly 20 cycles after ap_start rose; txn_done=0.
- cfg_num_txn=0 with go → finish=1 next cycle, ap_start never asserted. Then N=1 with go from FINISH → counters cleared, one transaction runs.
- reset=0 for one edge during WAIT_DONE of txn 2 of 5 → all outputs zero next cycle, state IDLE; a new go runs 5 transactions from txn_done=0.
